sync_fifo_out_arbiter: RTL and testbench

Round-robin, burst-locking arbiter that shares the single output command FIFO (`sync_fifo_out`, width `FIFO_CMD_LENGTH_OUT`) among NUM_REQ result producers. It sits in front of the FIFO's slave port. It grants one requester at a time and forwards that requester's beats through a one-entry output register. It releases the grant at end of packet or after MAX_BURST beats, so that no producer starves the others.

---
 rtl/sync_fifo_out_arbiter.sv | 130 +++++++++++++
 tb/tb_sync_fifo_out_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_out_arbiter.sv
// Round-robin, burst-locking arbiter sharing the output command FIFO among NUM_REQ producers.
// One idle cycle arbitrates, then beats pass through a one-entry register (2-cycle latency); s_ready follows the output slot.
`ifndef FIFO_CMD_LENGTH_OUT
`define FIFO_CMD_LENGTH_OUT 64
`endif

module sync_fifo_out_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = `FIFO_CMD_LENGTH_OUT,
  parameter int MAX_BURST = 8,
  parameter int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic [NUM_REQ-1:0]        s_valid,
  output logic [NUM_REQ-1:0]        s_ready,
  input  logic [NUM_REQ*DATA_W-1:0] s_data,
  input  logic [NUM_REQ-1:0]        s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_last,
  output logic [SRC_W-1:0]          m_src,
  output logic                      busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [SRC_W:0]   NUM_REQ_W  = (SRC_W + 1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_REQ   = SRC_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] gnt, gnt_nxt;
  logic [SRC_W-1:0] rr_ptr, rr_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             slot_free, accept, burst_end;
  logic             win_found;
  logic [SRC_W-1:0] win_idx, cand_idx;
  logic [SRC_W:0]   scan_idx;
  logic [DATA_W-1:0] s_slice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign s_slice[g] = s_data[g*DATA_W +: DATA_W];
  end

  assign slot_free = ~m_valid | m_ready;
  assign busy      = (state == GRANT);

  // Cyclic scan starting at rr_ptr; one extra bit lets the sum wrap for any NUM_REQ.
  always_comb begin : rr_scan
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + (SRC_W + 1)'(i);
      if (scan_idx >= NUM_REQ_W) scan_idx = scan_idx - NUM_REQ_W;
      cand_idx = scan_idx[SRC_W-1:0];
      if (!win_found && s_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin : fsm_comb
    state_nxt = state;
    gnt_nxt   = gnt;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    s_ready   = '0;
    accept    = 1'b0;
    burst_end = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = GRANT;
          gnt_nxt   = win_idx;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        s_ready[gnt] = slot_free;
        accept       = s_valid[gnt] & slot_free;
        burst_end    = s_last[gnt] | (beat_cnt == BURST_LAST);
        if (accept) begin
          cnt_nxt = beat_cnt + CNT_W'(1);
          if (burst_end) begin
            state_nxt = IDLE;
            rr_nxt    = (gnt == LAST_REQ) ? '0 : gnt + SRC_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin : fsm_reg
    if (!resetb) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // Payload fields hold when nothing is loaded; only m_valid drains.
  always_ff @(posedge clk or negedge resetb) begin : out_reg
    if (!resetb) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_src   <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= s_slice[gnt];
      m_last  <= burst_end;
      m_src   <= gnt;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_out_arbiter.sv
// Directed bench for sync_fifo_out_arbiter: requester queues drive beats, output beats are logged
// with their cycle index and compared against hand-computed sequences.
module tb_sync_fifo_out_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int MB = 8;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             resetb = 1'b0;
  logic [NR-1:0]    s_valid = '0;
  logic [NR-1:0]    s_ready;
  logic [NR*DW-1:0] s_data = '0;
  logic [NR-1:0]    s_last = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DW-1:0]    m_data;
  logic             m_last;
  logic [SW-1:0]    m_src;
  logic             busy;

  always #5 clk = ~clk;

  sync_fifo_out_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB), .SRC_W(SW)) dut (
    .clk(clk), .resetb(resetb),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_src(m_src), .busy(busy)
  );

  logic [DW-1:0] rq_d [NR][32];
  logic          rq_l [NR][32];
  int            rq_n [NR];
  int            rq_h [NR];
  logic [DW-1:0] ob_d [64];
  logic          ob_l [64];
  logic [SW-1:0] ob_s [64];
  int            ob_c [64];
  int            ob_n = 0;
  int            cyc = 0;
  logic          mr = 1'b1;
  int            checks = 0;
  int            passes = 0;
  int            fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    for (int i = 0; i < NR; i++) begin
      rq_n[i] = 0;
      rq_h[i] = 0;
    end
    ob_n    = 0;
    s_valid = '0;
    s_last  = '0;
  endtask

  task automatic push_pkt(input int r, input int len, input int base);
    for (int k = 0; k < len; k++) begin
      rq_d[r][rq_n[r]] = DW'((r << 8) | (base + k));
      rq_l[r][rq_n[r]] = (k == len - 1);
      rq_n[r]++;
    end
  endtask

  // Drive on the falling edge, observe 1 ns later; handshakes seen here complete at the next rising edge.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (rq_h[i] < rq_n[i]) begin
        s_valid[i]          = 1'b1;
        s_data[i*DW +: DW]  = rq_d[i][rq_h[i]];
        s_last[i]           = rq_l[i][rq_h[i]];
      end else begin
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
      end
    end
    m_ready = mr;
    #1;
    if (m_valid && m_ready && ob_n < 64) begin
      ob_d[ob_n] = m_data;
      ob_l[ob_n] = m_last;
      ob_s[ob_n] = m_src;
      ob_c[ob_n] = cyc;
      ob_n++;
    end
    for (int i = 0; i < NR; i++)
      if (s_valid[i] && s_ready[i]) rq_h[i]++;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int c0;
    int n1;
    int n3;
    logic [15:0] src_pack;
    logic [5:0]  last_pack;
    logic        exp_last;
    logic [SW-1:0] exp_src;
    logic [DW-1:0] exp_dat;

    // Inputs toggle while reset is held: nothing may move.
    clear();
    push_pkt(0, 2, 0);
    push_pkt(1, 2, 0);
    run(3);
    check("rst_hold_no_beat", ob_n, 0);
    check("rst_hold_m_valid", m_valid, 1'b0);
    check("rst_hold_s_ready", s_ready, 4'h0);
    check("rst_hold_busy", busy, 1'b0);
    clear();
    resetb = 1'b1;

    // Asynchronous pulse in mid-cycle while beats are in flight.
    push_pkt(1, 4, 0);
    run(4);
    check("pre_pulse_m_valid", m_valid, 1'b1);
    @(posedge clk);
    #3;
    resetb = 1'b0;
    #1;
    check("pulse_m_valid", m_valid, 1'b0);
    check("pulse_m_data", m_data, 16'h0000);
    check("pulse_m_last", m_last, 1'b0);
    check("pulse_m_src", m_src, 2'd0);
    check("pulse_s_ready", s_ready, 4'h0);
    check("pulse_busy", busy, 1'b0);
    clear();
    @(negedge clk);
    resetb = 1'b1;
    run(5);
    check("post_rst_no_beat", ob_n, 0);
    check("post_rst_busy", busy, 1'b0);

    // Single requester 2, three beats.
    clear();
    c0 = cyc;
    push_pkt(2, 3, 0);
    run(8);
    check("single_count", ob_n, 3);
    check("single_first_cyc", ob_c[0], c0 + 2);
    check("single_last_cyc", ob_c[2], c0 + 4);
    check("single_src", {ob_s[0], ob_s[1], ob_s[2]}, 6'b10_10_10);
    check("single_d0", ob_d[0], 16'h0200);
    check("single_d1", ob_d[1], 16'h0201);
    check("single_d2", ob_d[2], 16'h0202);
    check("single_last", {ob_l[0], ob_l[1], ob_l[2]}, 3'b001);
    check("single_busy_after", busy, 1'b0);

    // Round robin: pointer sits at 3 after requester 2's grant.
    clear();
    for (int r = 0; r < NR; r++) begin
      push_pkt(r, 1, 0);
      push_pkt(r, 1, 1);
    end
    run(20);
    check("rr_count", ob_n, 8);
    src_pack = '0;
    for (int k = 0; k < 8; k++) src_pack = {src_pack[13:0], ob_s[k]};
    check("rr_src_order", src_pack, 16'hC6C6);
    for (int k = 1; k < 8; k++) check($sformatf("rr_gap%0d", k), ob_c[k] - ob_c[k-1], 2);
    check("rr_d0", ob_d[0], 16'h0300);
    check("rr_d4", ob_d[4], 16'h0301);

    // Burst cap: requester 1 (20 beats) split at 8, requester 3 served in between.
    clear();
    push_pkt(1, 20, 0);
    cycle();
    push_pkt(3, 2, 0);
    run(40);
    check("burst_count", ob_n, 22);
    n1 = 0;
    n3 = 0;
    for (int k = 0; k < 22; k++) begin
      exp_src  = (k >= 8 && k < 10) ? 2'd3 : 2'd1;
      exp_last = (k == 7) || (k == 9) || (k == 17) || (k == 21);
      if (exp_src == 2'd3) begin
        exp_dat = 16'h0300 + DW'(n3);
        n3++;
      end else begin
        exp_dat = 16'h0100 + DW'(n1);
        n1++;
      end
      check($sformatf("burst_src%0d", k), ob_s[k], exp_src);
      check($sformatf("burst_last%0d", k), ob_l[k], exp_last);
      check($sformatf("burst_dat%0d", k), ob_d[k], exp_dat);
    end

    // Back-pressure for 5 cycles with beat 2 parked in the output register.
    clear();
    push_pkt(0, 6, 0);
    mr = 1'b1;
    run(4);
    mr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("bp_valid%0d", k), m_valid, 1'b1);
      check($sformatf("bp_data%0d", k), m_data, 16'h0002);
      check($sformatf("bp_ready%0d", k), s_ready, 4'h0);
    end
    mr = 1'b1;
    run(12);
    check("bp_count", ob_n, 6);
    for (int k = 0; k < 6; k++) check($sformatf("bp_seq%0d", k), ob_d[k], DW'(k));
    last_pack = '0;
    for (int k = 0; k < 6; k++) last_pack = {last_pack[4:0], ob_l[k]};
    check("bp_last", last_pack, 6'b000001);

    // Reset during beat 4 of 6; arbitration priority restarts at requester 0.
    clear();
    push_pkt(2, 6, 0);
    run(6);
    check("mid_pre_count", ob_n, 4);
    resetb = 1'b0;
    #1;
    check("mid_m_valid", m_valid, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_s_ready", s_ready, 4'h0);
    clear();
    @(negedge clk);
    resetb = 1'b1;
    push_pkt(3, 1, 0);
    push_pkt(0, 1, 0);
    run(8);
    check("mid_post_count", ob_n, 2);
    check("mid_post_src0", ob_s[0], 2'd0);
    check("mid_post_src1", ob_s[1], 2'd3);
    check("mid_post_d0", ob_d[0], 16'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
